// File: rtl/apb_cmd_master.sv
// APB3 initiator: single read/write commands in, SETUP/ACCESS transfers out,
// read data and error/timeout status returned on a response handshake.
module apb_cmd_master #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [31:0]   PWDATA,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic          cmd_ready_nx;
  logic          rsp_valid_nx;
  logic [31:0]   rsp_rdata_nx;
  logic          rsp_err_nx;
  logic          rsp_timeout_nx;
  logic          psel_nx;
  logic          penable_nx;
  logic          pwrite_nx;
  logic [AW-1:0] paddr_nx;
  logic [31:0]   pwdata_nx;

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    rsp_valid_nx   = rsp_valid;
    rsp_rdata_nx   = rsp_rdata;
    rsp_err_nx     = rsp_err;
    rsp_timeout_nx = rsp_timeout;
    psel_nx        = PSEL;
    penable_nx     = PENABLE;
    pwrite_nx      = PWRITE;
    paddr_nx       = PADDR;
    pwdata_nx      = PWDATA;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_nx = cmd_write;
          paddr_nx  = cmd_addr;
          pwdata_nx = cmd_wdata;
          psel_nx   = 1'b1;
          state_nx  = SETUP;
        end
      end
      SETUP: begin
        penable_nx = 1'b1;
        cnt_nx     = '0;
        state_nx   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over a coincident terminal count
        if (PREADY) begin
          psel_nx        = 1'b0;
          penable_nx     = 1'b0;
          rsp_rdata_nx   = PWRITE ? 32'h0 : PRDATA;
          rsp_err_nx     = PSLVERR;
          rsp_timeout_nx = 1'b0;
          rsp_valid_nx   = 1'b1;
          state_nx       = RESP;
        end else if (TO_EN && (cnt == TERM)) begin
          psel_nx        = 1'b0;
          penable_nx     = 1'b0;
          rsp_rdata_nx   = 32'h0;
          rsp_err_nx     = 1'b1;
          rsp_timeout_nx = 1'b1;
          rsp_valid_nx   = 1'b1;
          state_nx       = RESP;
        end else if (!(&cnt)) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    cmd_ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= 32'h0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      cmd_ready   <= cmd_ready_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_err     <= rsp_err_nx;
      rsp_timeout <= rsp_timeout_nx;
      PSEL        <= psel_nx;
      PENABLE     <= penable_nx;
      PWRITE      <= pwrite_nx;
      PADDR       <= paddr_nx;
      PWDATA      <= pwdata_nx;
    end
  end

endmodule
